fixed_requant: RTL and testbench

FIXED_REQUANT -- requirements
Module: fixed_requant

---
 rtl/fixed_requant_if.sv | 27 ++
 rtl/fixed_requant.sv | 108 ++++++++++
 tb/tb_fixed_requant.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fixed_requant_if.sv
// Stream bundle for fixed_requant: an input beat channel from the MAC and a
// requantized output channel, both valid/ready.
interface fixed_requant_if #(
    parameter int DW_IN  = 20,
    parameter int DW_OUT = 16
);
    logic [DW_IN-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              in_ovf;
    logic [DW_OUT-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              out_sat;

    modport master (
        output in_data, in_valid, in_last, in_ovf, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sat
    );

    modport slave (
        input  in_data, in_valid, in_last, in_ovf, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sat
    );
endinterface

// File: rtl/fixed_requant.sv
// Requantizes signed MAC results to a narrower fixed-point format with optional
// round-half-up and saturation, buffered by a 2-entry in-order FIFO.
module fixed_requant #(
    parameter int WII = 7,
    parameter int WFI = 13,
    parameter int WIR = 4,
    parameter int WFR = 12,
    parameter int RND = 1
) (
    input  logic           clk,
    input  logic           reset,
    fixed_requant_if.slave bus,
    output logic [15:0]    sat_count,
    input  logic           sat_clear
);
    localparam int WI  = WII + WFI;
    localparam int WR  = WIR + WFR;
    localparam int LSH = (WFR >= WFI) ? (WFR - WFI) : 0;
    localparam int RSH = (WFR <  WFI) ? (WFI - WFR) : 0;
    // Wide enough that the rounding add and any left shift never wrap.
    localparam int WC  = WI + LSH + WR + 2;
    localparam int EW  = WR + 2;

    localparam logic signed [WC-1:0] RBIAS =
        (RND != 0 && RSH > 0) ? (WC'(1) << ((RSH > 0) ? (RSH - 1) : 0)) : '0;
    localparam logic signed [WC-1:0] MAXV = {{(WC-WR+1){1'b0}}, {(WR-1){1'b1}}};
    localparam logic signed [WC-1:0] MINV = {{(WC-WR+1){1'b1}}, {(WR-1){1'b0}}};

    logic signed [WC-1:0] ext;
    logic signed [WC-1:0] rnd;
    logic signed [WC-1:0] scaled;
    logic [WR-1:0]        res;
    logic                 clamp;
    logic                 sat_beat;

    always_comb begin
        ext    = {{(WC-WI){bus.in_data[WI-1]}}, bus.in_data};
        rnd    = ext + RBIAS;
        scaled = (rnd <<< LSH) >>> RSH;
        clamp  = 1'b0;
        res    = scaled[WR-1:0];
        if (scaled > MAXV) begin
            res   = MAXV[WR-1:0];
            clamp = 1'b1;
        end else if (scaled < MINV) begin
            res   = MINV[WR-1:0];
            clamp = 1'b1;
        end
        sat_beat = clamp | bus.in_ovf;
    end

    logic [EW-1:0] mem_q [0:1];
    logic [EW-1:0] mem_d [0:1];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          rdy_en_q, rdy_en_d;
    logic [15:0]   sat_count_q, sat_count_d;
    logic          push, pop;

    // in_ready comes only from flops so it never loops through out_ready.
    assign bus.in_ready  = rdy_en_q & (cnt_q != 2'd2);
    assign bus.out_valid = (cnt_q != 2'd0);
    assign {bus.out_data, bus.out_last, bus.out_sat} = mem_q[rd_ptr_q];
    assign sat_count     = sat_count_q;

    always_comb begin
        push        = bus.in_valid & bus.in_ready;
        pop         = bus.out_valid & bus.out_ready;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rdy_en_d    = 1'b1;
        sat_count_d = sat_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {res, bus.in_last, sat_beat};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (push && sat_beat && sat_count_q != '1) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            rdy_en_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rdy_en_q    <= rdy_en_d;
            sat_count_q <= sat_count_d;
        end
    end
endmodule

// File: tb/tb_fixed_requant.sv
// Checks two fixed_requant instances (round-half-up and truncate) fed the same
// stream against a real-arithmetic reference and an in-order expectation queue.
module tb_fixed_requant;
    localparam int WII = 7, WFI = 13, WIR = 4, WFR = 12;
    localparam int WI = WII + WFI, WR = WIR + WFR;

    typedef struct {
        logic [WR-1:0] d1;
        logic          s1;
        logic [WR-1:0] d0;
        logic          s0;
        logic          last;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        sat_clear;
    logic [15:0] sat_count1, sat_count0;

    fixed_requant_if #(.DW_IN(WI), .DW_OUT(WR)) ifm ();
    fixed_requant_if #(.DW_IN(WI), .DW_OUT(WR)) ifz ();

    assign ifz.in_data   = ifm.in_data;
    assign ifz.in_valid  = ifm.in_valid;
    assign ifz.in_last   = ifm.in_last;
    assign ifz.in_ovf    = ifm.in_ovf;
    assign ifz.out_ready = ifm.out_ready;

    fixed_requant #(.WII(WII), .WFI(WFI), .WIR(WIR), .WFR(WFR), .RND(1)) dut1 (
        .clk(clk), .reset(reset), .bus(ifm), .sat_count(sat_count1), .sat_clear(sat_clear)
    );
    fixed_requant #(.WII(WII), .WFI(WFI), .WIR(WIR), .WFR(WFR), .RND(0)) dut0 (
        .clk(clk), .reset(reset), .bus(ifz), .sat_count(sat_count0), .sat_clear(sat_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    int unsigned sc1 = 0, sc0 = 0;
    logic        last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scale by 2^WFR/2^WFI in real arithmetic, then round or floor, then clamp.
    function automatic logic [WR:0] model(input logic [WI-1:0] d, input logic ovf, input bit rnd_mode);
        longint v;
        real    x;
        longint r;
        longint maxv, minv;
        bit     c;
        v    = longint'($signed(d));
        x    = real'(v) * (2.0 ** WFR) / (2.0 ** WFI);
        x    = (rnd_mode && WFR < WFI) ? $floor(x + 0.5) : $floor(x);
        r    = longint'(x);
        maxv = (longint'(1) << (WR - 1)) - 1;
        minv = -(longint'(1) << (WR - 1));
        c    = 1'b0;
        if (r > maxv) begin r = maxv; c = 1'b1; end
        if (r < minv) begin r = minv; c = 1'b1; end
        return {c | ovf, r[WR-1:0]};
    endfunction

    task automatic idle_inputs();
        ifm.in_valid  = 1'b0;
        ifm.in_data   = '0;
        ifm.in_last   = 1'b0;
        ifm.in_ovf    = 1'b0;
        ifm.out_ready = 1'b0;
        sat_clear     = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [WI-1:0] d, input logic last,
                         input logic ovf, input logic ordy, input logic clr);
        logic        acc, dlv;
        logic [WR:0] m1, m0;
        exp_t        e;
        ifm.in_valid  = v;
        ifm.in_data   = d;
        ifm.in_last   = last;
        ifm.in_ovf    = ovf;
        ifm.out_ready = ordy;
        sat_clear     = clr;
        @(negedge clk);
        acc = v && ifm.in_ready;
        dlv = ifm.out_valid && ordy;
        if (ifm.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", ifm.out_valid, 1'b0);
            end else begin
                chk("data_rnd1", ifm.out_data, q[0].d1);
                chk("sat_rnd1",  ifm.out_sat,  q[0].s1);
                chk("last_rnd1", ifm.out_last, q[0].last);
                chk("data_rnd0", ifz.out_data, q[0].d0);
                chk("sat_rnd0",  ifz.out_sat,  q[0].s0);
            end
        end
        if (dlv && q.size() != 0) void'(q.pop_front());
        if (acc) begin
            m1 = model(d, ovf, 1'b1);
            m0 = model(d, ovf, 1'b0);
            e.d1 = m1[WR-1:0]; e.s1 = m1[WR];
            e.d0 = m0[WR-1:0]; e.s0 = m0[WR];
            e.last = last;
            q.push_back(e);
        end
        if (clr) begin
            sc1 = 0; sc0 = 0;
        end else if (acc) begin
            if (m1[WR] && sc1 < 16'hFFFF) sc1++;
            if (m0[WR] && sc0 < 16'hFFFF) sc0++;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("sat_count1", sat_count1, 64'(sc1));
        chk("sat_count0", sat_count0, 64'(sc0));
        chk("out_valid_occ", ifm.out_valid, q.size() != 0);
        chk("in_ready_occ", ifm.in_ready, q.size() < 2);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [WI-1:0] rd;
        logic [31:0]   r;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ifm.out_valid, 1'b0);
        chk("rst_in_ready",  ifm.in_ready,  1'b0);
        chk("rst_out_data",  ifm.out_data,  '0);
        chk("rst_out_last",  ifm.out_last,  1'b0);
        chk("rst_out_sat",   ifm.out_sat,   1'b0);
        chk("rst_sat_count", sat_count1,    '0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", ifm.in_ready, 1'b1);

        // One-cycle latency into an empty FIFO, then basic rounding cases.
        cycle(1'b1, 20'h02000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("latency_valid", ifm.out_valid, 1'b1);
        chk("one_point_zero", ifm.out_data, 16'h1000);
        cycle(1'b1, 20'h02001, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 20'hFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 20'h14000, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 20'hEC000, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 20'h7FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        drain(2);
        chk("sat_count_three", sat_count1, 16'd3);

        // Backpressure: two accepts then stall, release delivers all three in order.
        cycle(1'b1, 20'h01000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 20'h03000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 20'h05000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_in_ready", ifm.in_ready, 1'b0);
        last_acc = 1'b0;
        for (int i = 0; i < 4 && !last_acc; i++) cycle(1'b1, 20'h05000, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("third_beat_accepted", last_acc, 1'b1);
        drain(3);

        // Upstream overflow flag, then clear beating a same-cycle saturating beat.
        cycle(1'b1, 20'h02000, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 20'h14000, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clear_priority", sat_count1, 16'd0);
        drain(2);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom;
            rd = r[0] ? r[31:12] : {{4{r[31]}}, r[31:16]};
            cycle(r[1] | r[2], rd, r[3], ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                  ($urandom_range(39) == 0));
        end
        drain(4);

        // Reset with two beats held; nothing stale afterwards.
        cycle(1'b1, 20'h14000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 20'h03000, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", ifm.out_valid, 1'b0);
        chk("midrst_sat_count", sat_count1, '0);
        q.delete();
        sc1 = 0; sc0 = 0;
        idle_inputs();
        @(posedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready", ifm.in_ready, 1'b1);
        cycle(1'b1, 20'h02000, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_data", ifm.out_data, 16'h1000);
        drain(3);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
